// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory access controller: state encoding,
// wait-counter sizing and the state-to-control-output decode.
package mem_access_ctrl_pkg;

    localparam int unsigned TIMEOUT_DEFAULT = 16;
    localparam int unsigned CNT_W           = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_MAR,
        RD_WAIT,
        RD_LATCH,
        WR_LOAD,
        WR_WAIT,
        DONE,
        ERR
    } state_e;

    typedef struct packed {
        logic mar_in;
        logic mdr_in;
        logic read;
        logic write;
        logic mem_en;
        logic busy;
        logic done;
        logic err;
    } ctrl_t;

    // Moore decode: the control word depends on the state alone.
    function automatic ctrl_t decode(input state_e s);
        ctrl_t c;
        c = '0;
        c.busy = (s != IDLE);
        unique case (s)
            LOAD_MAR: c.mar_in = 1'b1;
            RD_WAIT: begin
                c.mem_en = 1'b1;
                c.read   = 1'b1;
            end
            RD_LATCH: begin
                c.mdr_in = 1'b1;
                c.read   = 1'b1;
            end
            WR_LOAD: c.mdr_in = 1'b1;
            WR_WAIT: begin
                c.mem_en = 1'b1;
                c.write  = 1'b1;
            end
            DONE:    c.done = 1'b1;
            ERR:     c.err  = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_wait_timer.sv
// Wait-state counter: cleared outside the wait states, counts cycles without
// an acknowledge, and flags when the last permitted wait cycle is reached.
module wait_timer
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic Clock,
    input  logic Clear,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Clear) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory access sequencer: drives MAR/MDR load enables and memory strobes
// for single read or write accesses, with wait-state timeout abort.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic Clock,
    input  logic Clear,
    input  logic start,
    input  logic rw,
    input  logic mem_ready,
    output logic MARin,
    output logic MDRin,
    output logic Read,
    output logic Write,
    output logic mem_en,
    output logic busy,
    output logic done,
    output logic err
);

    state_e state_q;
    state_e state_d;
    logic   rw_q;
    logic   rw_d;
    ctrl_t  ctrl_q;
    logic   in_wait;
    logic   expired;

    assign in_wait = (state_q == RD_WAIT) || (state_q == WR_WAIT);

    wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_wait_timer (
        .Clock  (Clock),
        .Clear  (Clear),
        .clr    (!in_wait),
        .en     (in_wait && !mem_ready),
        .expired(expired)
    );

    // mem_ready is checked before expired so a late acknowledge still completes.
    always_comb begin
        state_d = state_q;
        rw_d    = rw_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD_MAR;
                    rw_d    = rw;
                end
            end
            LOAD_MAR: state_d = rw_q ? WR_LOAD : RD_WAIT;
            RD_WAIT: begin
                if (mem_ready) begin
                    state_d = RD_LATCH;
                end else if (expired) begin
                    state_d = ERR;
                end
            end
            RD_LATCH: state_d = DONE;
            WR_LOAD:  state_d = WR_WAIT;
            WR_WAIT: begin
                if (mem_ready) begin
                    state_d = DONE;
                end else if (expired) begin
                    state_d = ERR;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control word is registered with the state, so it always equals decode(state_q).
    always_ff @(posedge Clock) begin
        if (Clear) begin
            state_q <= IDLE;
            rw_q    <= 1'b0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            rw_q    <= rw_d;
            ctrl_q  <= decode(state_d);
        end
    end

    assign MARin  = ctrl_q.mar_in;
    assign MDRin  = ctrl_q.mdr_in;
    assign Read   = ctrl_q.read;
    assign Write  = ctrl_q.write;
    assign mem_en = ctrl_q.mem_en;
    assign busy   = ctrl_q.busy;
    assign done   = ctrl_q.done;
    assign err    = ctrl_q.err;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Cycle-by-cycle bench for mem_access_ctrl: each scenario queues per-cycle
// stimulus with the control word expected after the following clock edge.
module tb_mem_access_ctrl;

    logic Clock = 1'b0;
    logic Clear, start, rw, mem_ready;
    logic MARin, MDRin, Read, Write, mem_en, busy, done, err;
    logic [7:0] obs;

    // {MARin, MDRin, Read, Write, mem_en, busy, done, err}
    localparam logic [7:0] V_IDLE = 8'h00;
    localparam logic [7:0] V_MAR  = 8'h84;
    localparam logic [7:0] V_RDW  = 8'h2C;
    localparam logic [7:0] V_RDL  = 8'h64;
    localparam logic [7:0] V_WRL  = 8'h44;
    localparam logic [7:0] V_WRW  = 8'h1C;
    localparam logic [7:0] V_DONE = 8'h06;
    localparam logic [7:0] V_ERR  = 8'h05;

    typedef struct {
        logic       clr;
        logic       st;
        logic       w;
        logic       rdy;
        logic [7:0] exp;
    } stim_t;

    stim_t      stim_q[$];
    logic [7:0] sb_q[$];
    int         total = 0;
    int         bad   = 0;

    always #5 Clock = ~Clock;

    assign obs = {MARin, MDRin, Read, Write, mem_en, busy, done, err};

    mem_access_ctrl #(.TIMEOUT(16)) dut (
        .Clock    (Clock),
        .Clear    (Clear),
        .start    (start),
        .rw       (rw),
        .mem_ready(mem_ready),
        .MARin    (MARin),
        .MDRin    (MDRin),
        .Read     (Read),
        .Write    (Write),
        .mem_en   (mem_en),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    task automatic add(input logic c, input logic s, input logic w,
                       input logic r, input logic [7:0] e);
        stim_t t;
        t.clr = c; t.st = s; t.w = w; t.rdy = r; t.exp = e;
        stim_q.push_back(t);
    endtask

    task automatic test_reset();
        stim_t t;
        logic [7:0] e;
        int n = 0;
        add(1, 0, 0, 0, V_IDLE);
        add(1, 1, 1, 1, V_IDLE);
        add(0, 0, 0, 1, V_IDLE);
        while (stim_q.size() > 0) begin
            t = stim_q.pop_front();
            Clear = t.clr; start = t.st; rw = t.w; mem_ready = t.rdy;
            sb_q.push_back(t.exp);
            @(posedge Clock); #1;
            e = sb_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL reset cyc%0d: got %h want %h", n, obs, e);
            end
            n++;
        end
    endtask

    task automatic test_read_fast();
        stim_t t;
        logic [7:0] e;
        int n = 0;
        add(0, 1, 0, 1, V_MAR);
        add(0, 0, 0, 1, V_RDW);
        add(0, 0, 0, 1, V_RDL);
        add(0, 0, 0, 1, V_DONE);
        add(0, 0, 0, 1, V_IDLE);
        while (stim_q.size() > 0) begin
            t = stim_q.pop_front();
            Clear = t.clr; start = t.st; rw = t.w; mem_ready = t.rdy;
            sb_q.push_back(t.exp);
            @(posedge Clock); #1;
            e = sb_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL read_fast cyc%0d: got %h want %h", n, obs, e);
            end
            n++;
        end
    endtask

    task automatic test_write_wait();
        stim_t t;
        logic [7:0] e;
        int n = 0;
        add(0, 1, 1, 0, V_MAR);
        add(0, 0, 0, 0, V_WRL);
        add(0, 0, 0, 0, V_WRW);
        add(0, 0, 0, 0, V_WRW);
        add(0, 0, 0, 0, V_WRW);
        add(0, 0, 0, 0, V_WRW);
        add(0, 0, 0, 1, V_DONE);
        add(0, 0, 0, 0, V_IDLE);
        while (stim_q.size() > 0) begin
            t = stim_q.pop_front();
            Clear = t.clr; start = t.st; rw = t.w; mem_ready = t.rdy;
            sb_q.push_back(t.exp);
            @(posedge Clock); #1;
            e = sb_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL write_wait cyc%0d: got %h want %h", n, obs, e);
            end
            n++;
        end
    endtask

    task automatic test_timeout(input logic late_ready);
        stim_t t;
        logic [7:0] e;
        int n = 0;
        add(0, 1, 0, 0, V_MAR);
        add(0, 0, 0, 0, V_RDW);
        for (int unsigned i = 1; i < 16; i++) add(0, 0, 0, 0, V_RDW);
        if (late_ready) begin
            add(0, 0, 0, 1, V_RDL);
            add(0, 0, 0, 0, V_DONE);
        end else begin
            add(0, 0, 0, 0, V_ERR);
        end
        add(0, 0, 0, 0, V_IDLE);
        add(0, 0, 0, 0, V_IDLE);
        while (stim_q.size() > 0) begin
            t = stim_q.pop_front();
            Clear = t.clr; start = t.st; rw = t.w; mem_ready = t.rdy;
            sb_q.push_back(t.exp);
            @(posedge Clock); #1;
            e = sb_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL timeout(late=%0d) cyc%0d: got %h want %h",
                         late_ready, n, obs, e);
            end
            n++;
        end
    endtask

    task automatic test_clear_midwrite();
        stim_t t;
        logic [7:0] e;
        int n = 0;
        add(0, 1, 1, 0, V_MAR);
        add(0, 0, 1, 0, V_WRL);
        add(0, 0, 1, 0, V_WRW);
        add(0, 0, 1, 0, V_WRW);
        add(1, 0, 1, 1, V_IDLE);
        add(0, 0, 0, 1, V_IDLE);
        add(0, 1, 0, 1, V_MAR);
        add(0, 0, 0, 1, V_RDW);
        add(0, 0, 0, 1, V_RDL);
        add(0, 0, 0, 1, V_DONE);
        add(0, 0, 0, 1, V_IDLE);
        while (stim_q.size() > 0) begin
            t = stim_q.pop_front();
            Clear = t.clr; start = t.st; rw = t.w; mem_ready = t.rdy;
            sb_q.push_back(t.exp);
            @(posedge Clock); #1;
            e = sb_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL clear_midwrite cyc%0d: got %h want %h", n, obs, e);
            end
            n++;
        end
    endtask

    task automatic test_back_to_back();
        stim_t t;
        logic [7:0] e;
        int n = 0;
        add(0, 1, 0, 0, V_MAR);
        add(0, 1, 1, 0, V_RDW);
        add(0, 1, 1, 0, V_RDW);
        add(0, 0, 0, 0, V_RDW);
        add(0, 1, 1, 1, V_RDL);
        add(0, 1, 1, 0, V_DONE);
        add(0, 1, 0, 0, V_IDLE);
        add(0, 0, 0, 0, V_IDLE);
        add(0, 1, 1, 1, V_MAR);
        add(0, 0, 0, 1, V_WRL);
        add(0, 0, 0, 1, V_WRW);
        add(0, 0, 0, 1, V_DONE);
        add(0, 0, 0, 1, V_IDLE);
        while (stim_q.size() > 0) begin
            t = stim_q.pop_front();
            Clear = t.clr; start = t.st; rw = t.w; mem_ready = t.rdy;
            sb_q.push_back(t.exp);
            @(posedge Clock); #1;
            e = sb_q.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL back_to_back cyc%0d: got %h want %h", n, obs, e);
            end
            n++;
        end
    endtask

    initial begin
        Clear = 1'b1; start = 1'b0; rw = 1'b0; mem_ready = 1'b0;
        @(posedge Clock); #1;
        test_reset();
        test_read_fast();
        test_write_wait();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_clear_midwrite();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum wait-state cycles before an access is aborted; legal range 1..255.
REQ-002 Clock  in  1  single system clock; all state changes on its rising edge.
REQ-003 Clear  in  1  synchronous, active-high reset.
REQ-004 start  in  1  one-cycle request to begin an access; sampled only in IDLE.
REQ-005 rw  in  1  access type, captured with start: 0 = read, 1 = write.
REQ-006 mem_ready  in  1  memory acknowledge; sampled only in the wait states.
REQ-007 MARin  out  1  MAR load enable.
REQ-008 MDRin  out  1  MDR load enable.
REQ-009 Read  out  1  MDR input-mux select: 1 = Mdatain, 0 = BusMuxOut.
REQ-010 Write  out  1  memory write strobe.
REQ-011 mem_en  out  1  memory access enable.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 done  out  1  one-cycle pulse on successful completion.
REQ-014 err  out  1  one-cycle pulse on timeout abort.

Function
REQ-015 States SHALL be IDLE, LOAD_MAR, RD_WAIT, RD_LATCH, WR_LOAD, WR_WAIT, DONE and ERR.
REQ-016 Outputs SHALL be decoded from the state register only (Moore); no input-to-output combinational path.
REQ-017 IDLE: all outputs 0; start=1 -> LOAD_MAR and rw captured; start=0 -> stay in IDLE.
REQ-018 LOAD_MAR: MARin=1 for exactly one cycle; next state RD_WAIT if captured rw=0, WR_LOAD if rw=1.
REQ-019 RD_WAIT: mem_en=1, Read=1; mem_ready=1 -> RD_LATCH; otherwise stay, unless the timeout limit is reached.
REQ-020 RD_LATCH: MDRin=1, Read=1 for exactly one cycle -> DONE.
REQ-021 WR_LOAD: MDRin=1, Read=0 (MDR loads BusMuxOut) for one cycle -> WR_WAIT.
REQ-022 WR_WAIT: mem_en=1, Write=1, Read=0; mem_ready=1 -> DONE; otherwise stay, unless the timeout limit is reached.
REQ-023 DONE: done=1 for one cycle -> IDLE.
REQ-024 ERR: err=1 for one cycle -> IDLE; MDRin SHALL NOT assert on an aborted read.
REQ-025 Wait counter: 8-bit; zeroed on entry to RD_WAIT or WR_WAIT; increments each wait cycle with mem_ready=0.
REQ-026 Timeout: in a wait state with mem_ready=0 and counter = TIMEOUT-1 -> ERR.
REQ-027 Simultaneous events: mem_ready=1 in the timeout cycle SHALL win (completion, not ERR).
REQ-028 start asserted while busy=1 SHALL be ignored; the request is not queued.
REQ-029 rw SHALL be held internally for the whole access; rw changes after capture have no effect.
REQ-030 Read latency with mem_ready already high: start at cycle 0 -> MARin cycle 1, RD_WAIT cycle 2, MDRin cycle 3, done cycle 4.
REQ-031 Write latency with mem_ready already high: start at cycle 0 -> MARin cycle 1, MDRin cycle 2, Write cycle 3, done cycle 4.
REQ-032 MARin, MDRin and Write SHALL be mutually exclusive in every cycle.

Reset
REQ-033 Clear=1 at a rising edge SHALL force IDLE, zero the counter and captured rw, and drive all outputs to 0 in the next cycle, regardless of current state.
REQ-034 Clear SHALL take priority over start and mem_ready in the same cycle.
REQ-035 Clear asserted mid-access SHALL produce no done or err pulse.

Structure
REQ-036 A shared package SHALL hold the state enumeration, the default TIMEOUT constant and the counter width (8).
REQ-037 The wait counter and timeout compare SHALL be a sub-module, wait_timer (inputs: Clock, Clear, clr, en; output: expired).

Verification
REQ-038 Read, mem_ready tied high, start at cycle 0 -> MARin@1, Read+mem_en@2, MDRin+Read@3, done@4, busy low@5.
REQ-039 Write, mem_ready rising 3 cycles into WR_WAIT -> Write held 4 cycles, then done=1 for one cycle, err=0.
REQ-040 Read, mem_ready never asserted, TIMEOUT=16 -> 16 RD_WAIT cycles, then err=1 for one cycle, MDRin never high, then IDLE.
REQ-041 mem_ready=1 exactly in cycle 16 of the wait with TIMEOUT=16 -> RD_LATCH then done; err stays 0.
REQ-042 Clear during WR_WAIT -> next cycle all outputs 0, busy=0, no done or err; a new start then proceeds normally.
REQ-043 start pulsed during RD_WAIT, and rw toggled mid-access -> ignored; exactly one done, with read sequencing.
